// File: rtl/regset_traced.sv
// NREGS x DATA_W register file with two combinational read ports, one write port
// and a FWFT trace FIFO of accepted writes. Optional macro: WRITE_BYPASS_EN.
module regset_traced #(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG    = 1,
  parameter int TRACE_DEPTH = 8,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writable,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] Din,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] outa,
  output logic [DATA_W-1:0] outb,
  input  logic              trace_pop,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [CNT_W-1:0]  trace_count,
  output logic              trace_ovf
);

  localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [ADDR_W:0] NREGS_L = NREGS[ADDR_W:0];
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(TRACE_DEPTH);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [ADDR_W-1:0] mem_addr_q [TRACE_DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [TRACE_DEPTH];
  logic [DATA_W-1:0] mem_data_q [TRACE_DEPTH];
  logic [DATA_W-1:0] mem_data_d [TRACE_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_acc, pop_ok, full, do_push;

  // Address is live when inside the array and not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_acc  = writable && addr_live(rd);
    pop_ok  = trace_pop && (count_q != '0);
    full    = (count_q == DEPTH_L);
    // When full, a push only lands if a pop frees the head in the same cycle.
    do_push = wr_acc && (!full || pop_ok);

    regs_d     = regs_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q | (wr_acc && full && !pop_ok);

    if (wr_acc) regs_d[rd] = Din;
    if (do_push) begin
      mem_addr_d[wptr_q] = rd;
      mem_data_d[wptr_q] = Din;
      wptr_d             = wptr_q + PTR_W'(1);
    end
    if (pop_ok) rptr_d = rptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(pop_ok);
  end

  always_comb begin
    outa = addr_live(rs) ? regs_q[rs] : '0;
    outb = addr_live(rt) ? regs_q[rt] : '0;
`ifdef WRITE_BYPASS_EN
    if (wr_acc && (rd == rs)) outa = Din;
    if (wr_acc && (rd == rt)) outb = Din;
`endif
    trace_valid = (count_q != '0);
    trace_addr  = trace_valid ? mem_addr_q[rptr_q] : '0;
    trace_data  = trace_valid ? mem_data_q[rptr_q] : '0;
    trace_count = count_q;
    trace_ovf   = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
    // Trace storage is gated by the count, so it needs no reset.
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_regset_traced.sv
// Directed bench for regset_traced: vector table plus hand sequences for FIFO
// overflow, full push+pop, write forwarding and out-of-range addressing.
module tb_regset_traced;

  logic        clk = 1'b0;
  logic        reset;
  logic        writable;
  logic [4:0]  rd, rs, rt;
  logic [31:0] Din;
  logic        trace_pop;
  logic [31:0] outa, outb, outa2, outb2;
  logic        trace_valid, trace_valid2;
  logic [4:0]  trace_addr, trace_addr2;
  logic [31:0] trace_data, trace_data2;
  logic [3:0]  trace_count, trace_count2;
  logic        trace_ovf, trace_ovf2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regset_traced dut (
    .clk(clk), .reset(reset), .writable(writable), .rd(rd), .Din(Din),
    .rs(rs), .rt(rt), .outa(outa), .outb(outb), .trace_pop(trace_pop),
    .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_count(trace_count), .trace_ovf(trace_ovf)
  );

  regset_traced #(.NREGS(24)) dut2 (
    .clk(clk), .reset(reset), .writable(writable), .rd(rd), .Din(Din),
    .rs(rs), .rt(rt), .outa(outa2), .outb(outb2), .trace_pop(trace_pop),
    .trace_valid(trace_valid2), .trace_addr(trace_addr2), .trace_data(trace_data2),
    .trace_count(trace_count2), .trace_ovf(trace_ovf2)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        pop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ev;
    logic [4:0]  eaddr;
    logic [31:0] edata;
    logic [3:0]  ecnt;
    logic        eovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] ra, input logic [4:0] rb, input logic p);
    writable = w; rd = a; Din = d; rs = ra; rt = rb; trace_pop = p;
  endtask

  // Reset asserted together with a write and a pop; reset must win.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 5'd9, 32'd1, 5'd9, 5'd0, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0);
    #1;
  endtask

  logic [31:0] exp6;

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 32'd0,    5'd3, 5'd31, 1'b0, 32'd0,    32'd0,  1'b0, 5'd0, 32'd0,    4'd0, 1'b0};
    vecs[1]  = '{1'b1, 5'd2, 32'd12,   5'd3, 5'd5,  1'b0, 32'd0,    32'd0,  1'b0, 5'd0, 32'd0,    4'd0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'd0,    5'd2, 5'd0,  1'b0, 32'd12,   32'd0,  1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[3]  = '{1'b1, 5'd0, 32'd5,    5'd2, 5'd1,  1'b0, 32'd12,   32'd0,  1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'd0,    5'd0, 5'd2,  1'b0, 32'd0,    32'd12, 1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[5]  = '{1'b0, 5'd3, 32'd77,   5'd2, 5'd3,  1'b0, 32'd12,   32'd0,  1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'd0,    5'd3, 5'd2,  1'b0, 32'd0,    32'd12, 1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'd0,    5'd2, 5'd2,  1'b1, 32'd12,   32'd12, 1'b1, 5'd2, 32'd12,   4'd1, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'd0,    5'd2, 5'd0,  1'b1, 32'd12,   32'd0,  1'b0, 5'd0, 32'd0,    4'd0, 1'b0};
    vecs[9]  = '{1'b1, 5'd5, 32'h55,   5'd2, 5'd6,  1'b1, 32'd12,   32'd0,  1'b0, 5'd0, 32'd0,    4'd0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'd0,    5'd5, 5'd2,  1'b0, 32'h55,   32'd12, 1'b1, 5'd5, 32'h55,   4'd1, 1'b0};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].rs, vecs[i].rt, vecs[i].pop);
      #1;
      check($sformatf("v%0d outa", i),  outa,        vecs[i].ea);
      check($sformatf("v%0d outb", i),  outb,        vecs[i].eb);
      check($sformatf("v%0d valid", i), 32'(trace_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d taddr", i), 32'(trace_addr),  32'(vecs[i].eaddr));
      check($sformatf("v%0d tdata", i), trace_data,  vecs[i].edata);
      check($sformatf("v%0d count", i), 32'(trace_count), 32'(vecs[i].ecnt));
      check($sformatf("v%0d ovf", i),   32'(trace_ovf),   32'(vecs[i].eovf));
      tick();
    end

    // Overflow: nine writes into an 8-deep trace, then drain in order.
    do_reset();
    check("rst count", 32'(trace_count), 32'd0);
    check("rst r9", outa, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 5'(i), 32'(100 + i), 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("ovf count", 32'(trace_count), 32'd8);
    check("ovf flag", 32'(trace_ovf), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain addr %0d", i), 32'(trace_addr), 32'(i));
      check($sformatf("drain data %0d", i), trace_data, 32'(100 + i));
      tick();
    end
    check("drain valid", 32'(trace_valid), 32'd0);
    check("drain data0", trace_data, 32'd0);
    tick();
    check("underflow count", 32'(trace_count), 32'd0);
    check("ovf sticky", 32'(trace_ovf), 32'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    check("mid rst ovf", 32'(trace_ovf), 32'd0);
    check("mid rst valid", 32'(trace_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'(100 + i), 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("fullpp count", 32'(trace_count), 32'd8);
    check("fullpp ovf", 32'(trace_ovf), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("fullpp data %0d", i), trace_data, 32'(100 + i));
      tick();
    end
    trace_pop = 1'b0;
    #1;
    check("tail addr", 32'(trace_addr), 32'd4);
    check("tail data", trace_data, 32'h44);
    check("tail count", 32'(trace_count), 32'd1);

    // Same-cycle write and read of r7.
    do_reset();
    drive(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'hDEAD, 5'd7, 5'd7, 1'b0);
    #1;
`ifdef WRITE_BYPASS_EN
    exp6 = 32'hDEAD;
`else
    exp6 = 32'h11;
`endif
    check("same cyc outa", outa, exp6);
    check("same cyc outb", outb, exp6);
    tick();
    drive(1'b0, 5'd7, 32'hBEEF, 5'd7, 5'd0, 1'b0);
    #1;
    check("next cyc outa", outa, 32'hDEAD);
    drive(1'b1, 5'd0, 32'd5, 5'd0, 5'd0, 1'b0);
    #1;
    check("r0 no fwd", outa, 32'd0);
    tick();

    // Out-of-range write/read on a 24-register instance.
    do_reset();
    drive(1'b1, 5'd25, 32'd9, 5'd25, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd25, 5'd0, 1'b0);
    #1;
    check("oor read", outa2, 32'd0);
    check("oor count", 32'(trace_count2), 32'd0);
    check("inrange read", outa, 32'd9);
    check("inrange count", 32'(trace_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
